// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: byte width and drain-sequencer state encoding.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_STROBE    = 3'd2;
    localparam logic [2:0] ST_WAIT_RISE = 3'd3;
    localparam logic [2:0] ST_WAIT_FALL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD      = ST_LOAD,
        S_STROBE    = ST_STROBE,
        S_WAIT_RISE = ST_WAIT_RISE,
        S_WAIT_FALL = ST_WAIT_FALL
    } drain_state_e;

    // Counter width large enough to hold the larger of two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy flags and a registered read port that
// only updates on a pop, so the read register holds the last popped entry.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = UART_BYTE_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic [W-1:0]  r_rd_data;

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_next;

    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (AW+1)'(1);
            2'b01:   w_count_next = r_count - (AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == (AW+1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter: queues bus writes and launches them one at a
// time with a tx_int pulse, waiting on tx_busy (or a timeout) between frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int INT_CYCLES = 4,
    parameter int BUSY_WAIT  = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [UART_BYTE_W-1:0] i_wr_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [AW:0]            o_count,
    output logic                   o_overflow,
    input  logic                   i_clr_ovf,
    output logic [UART_BYTE_W-1:0] o_tx_data,
    output logic                   o_tx_int,
    input  logic                   i_tx_busy
);

    localparam int CNT_W = cnt_width(INT_CYCLES, BUSY_WAIT);

    drain_state_e           r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_tx_int;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_load;
    logic [UART_BYTE_W-1:0] w_rd_data;

    assign w_load = (r_state == S_LOAD);

    // The FIFO's registered read port doubles as the tx_data holding register.
    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (UART_BYTE_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_load),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (o_count)
    );

    // A same-cycle overflow wins over clear, so no rejected push goes unreported.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (i_wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tx_int <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && !i_tx_busy) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_STROBE;
                end
                // First STROBE cycle keeps tx_int low so tx_data settles a cycle ahead of it.
                S_STROBE: begin
                    if (r_cnt == CNT_W'(INT_CYCLES)) begin
                        r_tx_int <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_WAIT_RISE;
                    end else begin
                        r_tx_int <= 1'b1;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_FALL;
                    end else if (r_cnt == CNT_W'(BUSY_WAIT - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_FALL: begin
                    if (!i_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx_int <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;
    assign o_tx_data  = w_rd_data;
    assign o_tx_int   = r_tx_int;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural tx-stage busy model, a launch monitor,
// and a queue-based expectation of which bytes leave and in what order.
module tb_uart_tx_fifo;

    localparam int DEPTH      = 16;
    localparam int INT_CYCLES = 4;
    localparam int BUSY_WAIT  = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_int;
    logic       tx_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .AW         (4),
        .INT_CYCLES (INT_CYCLES),
        .BUSY_WAIT  (BUSY_WAIT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_overflow (overflow),
        .i_clr_ovf  (clr_ovf),
        .o_tx_data  (tx_data),
        .o_tx_int   (tx_int),
        .i_tx_busy  (tx_busy)
    );

    int assertCount = 0;
    int failCount   = 0;

    // tx-stage model: 0 = busy rises 2 cycles after tx_int falls for busyLen cycles,
    // 1 = busy forced high, 2 = busy tied low.
    int   busyMode  = 2;
    int   busyLen   = 100;
    int   busyDelay = 0;
    int   busyTimer = 0;
    logic prevIntB  = 1'b0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            case (busyMode)
                1: begin tx_busy = 1'b1; busyDelay = 0; busyTimer = 0; end
                2: begin tx_busy = 1'b0; busyDelay = 0; busyTimer = 0; end
                default: begin
                    if (prevIntB === 1'b1 && tx_int === 1'b0) busyDelay = 2;
                    if (busyDelay > 0) begin
                        busyDelay--;
                        if (busyDelay == 0) begin
                            tx_busy   = 1'b1;
                            busyTimer = busyLen;
                        end
                    end else if (busyTimer > 0) begin
                        busyTimer--;
                        if (busyTimer == 0) tx_busy = 1'b0;
                    end else begin
                        tx_busy = 1'b0;
                    end
                end
            endcase
            prevIntB = tx_int;
        end
    end

    // Launch monitor: logs every tx_int pulse and the conditions around it.
    int         cyc = 0;
    logic [7:0] sentQ[$];
    int         riseQ[$];
    int         widthQ[$];
    int         dataErr = 0;
    int         busyErr = 0;
    int         countErr = 0;
    int         pushesSeen = 0;
    bit         countCheckEn = 1'b0;
    int         clearSeq = 0;
    int         seenSeq = 0;
    logic       prevInt = 1'b0;
    logic [7:0] prevData = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (clearSeq != seenSeq) begin
                seenSeq = clearSeq;
                sentQ.delete();
                riseQ.delete();
                widthQ.delete();
                dataErr    = 0;
                busyErr    = 0;
                countErr   = 0;
                pushesSeen = 0;
            end
            if (tx_int === 1'b1 && prevInt !== 1'b1) begin
                sentQ.push_back(tx_data);
                riseQ.push_back(cyc);
                if (tx_data !== prevData) dataErr++;
                if (tx_busy !== 1'b0) busyErr++;
                if (countCheckEn && int'(count) != pushesSeen - sentQ.size()) countErr++;
            end else if (tx_int === 1'b1 && tx_data !== prevData) begin
                dataErr++;
            end
            if (tx_int === 1'b0 && prevInt === 1'b1 && riseQ.size() > 0)
                widthQ.push_back(cyc - riseQ[riseQ.size()-1]);
            if (rst !== 1'b1 && wr_en === 1'b1) pushesSeen++;
            prevInt  = tx_int;
            prevData = tx_data;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        stepCycles(1);
        wr_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        clearSeq++;
        stepCycles(1);
    endtask

    task automatic waitSent(input int n, input int budget, input string tag);
        int k = 0;
        while (sentQ.size() < n && k < budget) begin
            stepCycles(1);
            k++;
        end
        checkOutput(tag, 32'(sentQ.size()), 32'(n));
    endtask

    logic [7:0] expQ[$];
    logic [7:0] burst[4];
    logic [7:0] d;
    int         n;
    int         gap;
    int         k;

    initial begin
        burst = '{8'h55, 8'hAA, 8'h0F, 8'hF0};

        // Reset held two cycles while writes are attempted
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h77; clr_ovf = 1'b0; busyMode = 2;
        stepCycles(2);
        rst = 1'b0; wr_en = 1'b0;
        checkOutput("rst_count",    32'(count),    32'd0);
        checkOutput("rst_empty",    32'(empty),    32'd1);
        checkOutput("rst_full",     32'(full),     32'd0);
        checkOutput("rst_tx_int",   32'(tx_int),   32'd0);
        checkOutput("rst_tx_data",  32'(tx_data),  32'h00);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        stepCycles(10);
        checkOutput("rst_no_push_count", 32'(count), 32'd0);
        checkOutput("rst_no_pulse", 32'(sentQ.size()), 32'd0);

        // Single byte with a responsive tx stage
        $display("[TB] single byte");
        countCheckEn = 1'b1; busyMode = 0; busyLen = 100;
        clearLogs();
        applyStimulus(8'hA5);
        waitSent(1, 50, "t2_launch");
        checkOutput("t2_data", 32'(sentQ[0]), 32'hA5);
        checkOutput("t2_empty_after_load", 32'(empty), 32'd1);
        stepCycles(130);
        checkOutput("t2_width", 32'(widthQ[0]), 32'(INT_CYCLES));
        checkOutput("t2_data_stable", 32'(dataErr), 32'd0);
        checkOutput("t2_tx_int_low", 32'(tx_int), 32'd0);

        // Back-to-back burst keeps write order and waits out each frame
        $display("[TB] burst order");
        clearLogs();
        for (int i = 0; i < 4; i++) applyStimulus(burst[i]);
        waitSent(4, 800, "t3_launch");
        stepCycles(130);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_data%0d", i), 32'(sentQ[i]), 32'(burst[i]));
            checkOutput($sformatf("t3_width%0d", i), 32'(widthQ[i]), 32'(INT_CYCLES));
        end
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("t3_spacing%0d", i),
                        32'((riseQ[i] - riseQ[i-1]) >= busyLen + INT_CYCLES), 32'd1);
        checkOutput("t3_busy_at_rise", 32'(busyErr), 32'd0);
        checkOutput("t3_count_track", 32'(countErr), 32'd0);
        checkOutput("t3_data_stable", 32'(dataErr), 32'd0);
        checkOutput("t3_count_end", 32'(count), 32'd0);

        // Randomised bursts with random gaps and frame lengths
        $display("[TB] random bursts");
        for (int r = 0; r < 3; r++) begin
            busyLen = $urandom_range(5, 30);
            clearLogs();
            expQ.delete();
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                applyStimulus(d);
                expQ.push_back(d);
                stepCycles($urandom_range(0, 3));
            end
            waitSent(n, n * (busyLen + 20) + 50, $sformatf("t7_launch_r%0d", r));
            stepCycles(busyLen + 20);
            for (int i = 0; i < n; i++)
                checkOutput($sformatf("t7_data_r%0d_%0d", r, i), 32'(sentQ[i]), 32'(expQ[i]));
            checkOutput($sformatf("t7_count_track_r%0d", r), 32'(countErr), 32'd0);
            checkOutput($sformatf("t7_busy_at_rise_r%0d", r), 32'(busyErr), 32'd0);
            checkOutput($sformatf("t7_data_stable_r%0d", r), 32'(dataErr), 32'd0);
        end

        // Fill while the tx stage stays busy, then overflow handling
        $display("[TB] full and overflow");
        countCheckEn = 1'b0; busyMode = 1;
        stepCycles(3);
        clearLogs();
        expQ.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom);
            applyStimulus(d);
            if (i < DEPTH) expQ.push_back(d);
        end
        checkOutput("t4_full",     32'(full),     32'd1);
        checkOutput("t4_count",    32'(count),    32'(DEPTH));
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        checkOutput("t4_held_off", 32'(sentQ.size()), 32'd0);
        clr_ovf = 1'b1;
        stepCycles(1);
        clr_ovf = 1'b0;
        checkOutput("t4_clr_ovf", 32'(overflow), 32'd0);
        clr_ovf = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        stepCycles(1);
        clr_ovf = 1'b0; wr_en = 1'b0;
        checkOutput("t4_ovf_beats_clr", 32'(overflow), 32'd1);
        checkOutput("t4_count_kept", 32'(count), 32'(DEPTH));
        clr_ovf = 1'b1;
        stepCycles(1);
        clr_ovf = 1'b0;
        busyLen = 10; busyMode = 0;
        waitSent(DEPTH, DEPTH * 40, "t4_drain");
        stepCycles(80);
        for (int i = 0; i < DEPTH; i++)
            checkOutput($sformatf("t4_data%0d", i), 32'(sentQ[i]), 32'(expQ[i]));
        checkOutput("t4_dropped_never_sent", 32'(sentQ.size()), 32'(DEPTH));
        checkOutput("t4_drained_empty", 32'(empty), 32'd1);

        // tx stage never reports busy: each launch falls back on the timeout
        $display("[TB] busy timeout");
        busyMode = 2;
        clearLogs();
        expQ.delete();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            applyStimulus(d);
            expQ.push_back(d);
        end
        waitSent(3, 400, "t5_launch");
        stepCycles(BUSY_WAIT + 20);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("t5_data%0d", i), 32'(sentQ[i]), 32'(expQ[i]));
        for (int i = 1; i < 3; i++) begin
            gap = riseQ[i] - riseQ[i-1];
            checkOutput($sformatf("t5_gap%0d", i),
                        32'(gap >= BUSY_WAIT + INT_CYCLES + 3 && gap <= BUSY_WAIT + INT_CYCLES + 4),
                        32'd1);
        end
        checkOutput("t5_no_extra", 32'(sentQ.size()), 32'd3);
        checkOutput("t5_empty", 32'(empty), 32'd1);
        applyStimulus(8'h3C);
        stepCycles(4);
        checkOutput("t5_idle_relaunch", 32'(sentQ.size()), 32'd4);
        checkOutput("t5_idle_relaunch_data", 32'(sentQ[3]), 32'h3C);
        stepCycles(BUSY_WAIT + 20);

        // Reset while strobing with five bytes still queued
        $display("[TB] reset mid-operation");
        busyMode = 1;
        stepCycles(2);
        clearLogs();
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom));
        busyLen = 100; busyMode = 0;
        k = 0;
        while (tx_int !== 1'b1 && k < 20) begin
            stepCycles(1);
            k++;
        end
        checkOutput("t6_in_strobe", 32'(tx_int), 32'd1);
        checkOutput("t6_queued", 32'(count), 32'd5);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        checkOutput("t6_tx_int_drop", 32'(tx_int), 32'd0);
        checkOutput("t6_count",       32'(count),  32'd0);
        checkOutput("t6_empty",       32'(empty),  32'd1);
        checkOutput("t6_tx_data",     32'(tx_data), 32'h00);
        stepCycles(300);
        checkOutput("t6_no_more_pulses", 32'(sentQ.size()), 32'd1);
        checkOutput("t6_tx_int_idle", 32'(tx_int), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
